// File: rtl/dvd_bounce_engine.sv
// Multi-object one-cell bounce engine: steps N_OBJ objects inside a cell grid on
// vsync-derived frame ticks and renders a registered 6-bit RGB pixel.
module dvd_bounce_engine #(
    parameter int GRID_W          = 20,
    parameter int GRID_H          = 15,
    parameter int CELL_SHIFT      = 5,
    parameter int N_OBJ           = 2,
    parameter int FRAMES_PER_STEP = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 vsync,
    input  logic                 display_on,
    input  logic [9:0]           hpos,
    input  logic [9:0]           vpos,
    input  logic [2*N_OBJ-1:0]   dir_init,
    input  logic [5:0]           fg_color,
    input  logic [5:0]           bg_color,
    input  logic                 pause,
    output logic [5:0]           rgb,
    output logic                 frame_tick,
    output logic [N_OBJ-1:0]     bounce_pulse,
    output logic                 corner_hit
);

    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);

    logic             vsync_q;
    logic             vsync_armed;
    logic             step_en;
    logic [3:0]       fcnt;

    logic [XW-1:0]    pos_x  [N_OBJ];
    logic [YW-1:0]    pos_y  [N_OBJ];
    logic [5:0]       colour [N_OBJ];
    logic [N_OBJ-1:0] dir_x;
    logic [N_OBJ-1:0] dir_y;
    logic [N_OBJ-1:0] hit_x;
    logic [N_OBJ-1:0] hit_y;

    logic [9:0]       cell_x;
    logic [9:0]       cell_y;
    logic [5:0]       pix;

    // vsync_armed blocks a tick until vsync has been seen low after reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vsync_q     <= 1'b0;
            vsync_armed <= 1'b0;
            frame_tick  <= 1'b0;
        end else begin
            vsync_q     <= vsync;
            vsync_armed <= vsync_armed | ~vsync;
            frame_tick  <= vsync & ~vsync_q & vsync_armed;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fcnt    <= '0;
            step_en <= 1'b0;
        end else begin
            step_en <= 1'b0;
            if (frame_tick && !pause) begin
                if (fcnt == 4'(FRAMES_PER_STEP - 1)) begin
                    fcnt    <= '0;
                    step_en <= 1'b1;
                end else begin
                    fcnt <= fcnt + 4'd1;
                end
            end
        end
    end

    always_comb begin
        hit_x = '0;
        hit_y = '0;
        for (int unsigned k = 0; k < N_OBJ; k++) begin
            hit_x[k] = dir_x[k] ? (pos_x[k] == XW'(GRID_W - 1)) : (pos_x[k] == '0);
            hit_y[k] = dir_y[k] ? (pos_y[k] == YW'(GRID_H - 1)) : (pos_y[k] == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < N_OBJ; k++) begin
                pos_x[k]  <= XW'((7 * k) % GRID_W);
                pos_y[k]  <= YW'((5 * k + 1) % GRID_H);
                dir_x[k]  <= dir_init[2*k+1];
                dir_y[k]  <= dir_init[2*k];
                colour[k] <= fg_color;
            end
            bounce_pulse <= '0;
            corner_hit   <= 1'b0;
        end else begin
            bounce_pulse <= '0;
            corner_hit   <= 1'b0;
            if (step_en) begin
                for (int unsigned k = 0; k < N_OBJ; k++) begin
                    if (hit_x[k])
                        dir_x[k] <= ~dir_x[k];
                    else
                        pos_x[k] <= dir_x[k] ? pos_x[k] + XW'(1) : pos_x[k] - XW'(1);
                    if (hit_y[k])
                        dir_y[k] <= ~dir_y[k];
                    else
                        pos_y[k] <= dir_y[k] ? pos_y[k] + YW'(1) : pos_y[k] - YW'(1);
                    if (hit_x[k] || hit_y[k])
                        colour[k] <= {colour[k][3:0], colour[k][5:4]};
                end
                bounce_pulse <= hit_x | hit_y;
                corner_hit   <= |(hit_x & hit_y);
            end
        end
    end

    assign cell_x = hpos >> CELL_SHIFT;
    assign cell_y = vpos >> CELL_SHIFT;

    // Scan from the highest index down so the lowest-index hit wins
    always_comb begin
        pix = bg_color;
        for (int unsigned k = N_OBJ; k > 0; k--) begin
            if (cell_x == 10'(pos_x[k-1]) && cell_y == 10'(pos_y[k-1]))
                pix = colour[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            rgb <= '0;
        else
            rgb <= display_on ? pix : '0;
    end

endmodule

// File: tb/tb_dvd_bounce_engine.sv
// Randomized bench for dvd_bounce_engine against a frame-level bounce model;
// objects are observed through the rendered pixel stream and the pulse outputs.
module tb_dvd_bounce_engine;

    localparam int GW  = 9;
    localparam int GH  = 7;
    localparam int CS  = 5;
    localparam int NO  = 2;
    localparam int FPS = 3;
    localparam int CELL = 1 << CS;

    logic              clk;
    logic              rst_n;
    logic              vsync;
    logic              display_on;
    logic [9:0]        hpos;
    logic [9:0]        vpos;
    logic [2*NO-1:0]   dir_init;
    logic [5:0]        fg_color;
    logic [5:0]        bg_color;
    logic              pause;
    logic [5:0]        rgb;
    logic              frame_tick;
    logic [NO-1:0]     bounce_pulse;
    logic              corner_hit;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: positions, unit velocities (+1/-1), colours, frame count
    int mx [NO];
    int my [NO];
    int mdx[NO];
    int mdy[NO];
    int mc [NO];
    int mcnt;

    dvd_bounce_engine #(
        .GRID_W(GW), .GRID_H(GH), .CELL_SHIFT(CS), .N_OBJ(NO), .FRAMES_PER_STEP(FPS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .vsync(vsync), .display_on(display_on),
        .hpos(hpos), .vpos(vpos), .dir_init(dir_init), .fg_color(fg_color),
        .bg_color(bg_color), .pause(pause), .rgb(rgb), .frame_tick(frame_tick),
        .bounce_pulse(bounce_pulse), .corner_hit(corner_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < NO; k++) begin
            mx[k]  = (7 * k) % GW;
            my[k]  = (5 * k + 1) % GH;
            mdx[k] = dir_init[2*k+1] ? 1 : -1;
            mdy[k] = dir_init[2*k]   ? 1 : -1;
            mc[k]  = fg_color;
        end
        mcnt = 0;
    endtask

    task automatic model_step(output int bp, output int ch);
        bit bx, by;
        bp = 0;
        ch = 0;
        for (int k = 0; k < NO; k++) begin
            bx = (mdx[k] == 1 && mx[k] == GW - 1) || (mdx[k] == -1 && mx[k] == 0);
            by = (mdy[k] == 1 && my[k] == GH - 1) || (mdy[k] == -1 && my[k] == 0);
            if (bx) mdx[k] = -mdx[k]; else mx[k] += mdx[k];
            if (by) mdy[k] = -mdy[k]; else my[k] += mdy[k];
            if (bx || by) begin
                mc[k] = ((mc[k] << 2) | (mc[k] >> 4)) & 63;
                bp |= (1 << k);
            end
            if (bx && by) ch = 1;
        end
    endtask

    function automatic int exp_rgb(input int h, input int v, input bit d);
        int cx, cy;
        if (!d) return 0;
        cx = h / CELL;
        cy = v / CELL;
        for (int k = 0; k < NO; k++)
            if (cx == mx[k] && cy == my[k]) return mc[k];
        return bg_color;
    endfunction

    // One vsync pulse of 'hold' cycles; pulses expected on the 3rd edge after rise
    task automatic run_frame(input int hold, input bit p);
        int bp, ch, n;
        bp = 0;
        ch = 0;
        if (!p) begin
            mcnt++;
            if (mcnt == FPS) begin
                mcnt = 0;
                model_step(bp, ch);
            end
        end
        pause = p;
        vsync = 1'b1;
        n = ((hold > 3) ? hold : 3) + 2;
        for (int i = 1; i <= n; i++) begin
            cyc();
            check_eq("frame_tick", frame_tick, (i == 1) ? 1 : 0);
            check_eq("bounce_pulse", bounce_pulse, (i == 3) ? bp : 0);
            check_eq("corner_hit", corner_hit, (i == 3) ? ch : 0);
            if (i == hold) vsync = 1'b0;
        end
        pause = 1'b0;
    endtask

    task automatic check_pixel(input string tag, input int h, input int v, input bit d);
        hpos = 10'(h);
        vpos = 10'(v);
        display_on = d;
        cyc();
        check_eq(tag, rgb, exp_rgb(h, v, d));
    endtask

    task automatic check_pixels();
        for (int k = 0; k < NO; k++)
            check_pixel("rgb_obj", mx[k] * CELL + $urandom_range(CELL - 1, 0),
                        my[k] * CELL + $urandom_range(CELL - 1, 0), 1'b1);
        bg_color = 6'($urandom);
        check_pixel("rgb_any", $urandom_range(1023, 0), $urandom_range(1023, 0),
                    1'($urandom_range(1, 0)));
    endtask

    task automatic do_reset(input logic [2*NO-1:0] dirs, input logic [5:0] fg);
        rst_n = 1'b0;
        vsync = 1'b0;
        dir_init = dirs;
        fg_color = fg;
        display_on = 1'b1;
        cyc();
        cyc();
        check_eq("rst_rgb", rgb, 0);
        check_eq("rst_tick", frame_tick, 0);
        check_eq("rst_bounce", bounce_pulse, 0);
        check_eq("rst_corner", corner_hit, 0);
        rst_n = 1'b1;
        model_reset();
        cyc();
        cyc();
    endtask

    initial begin
        rst_n = 1'b0;
        vsync = 1'b0;
        display_on = 1'b0;
        hpos = '0;
        vpos = '0;
        pause = 1'b0;
        dir_init = '0;
        fg_color = '0;
        bg_color = 6'b000101;

        // Directed start: all objects moving +x/+y, known colour
        do_reset(4'b1111, 6'b110000);
        check_pixel("reset_obj0", 0 * CELL + 3, 1 * CELL + 3, 1'b1);
        repeat (2 * FPS) run_frame(2, 1'b0);
        check_pixel("obj0_at_2_3", 70, 100, 1'b1);
        check_eq("obj0_colour", rgb, 6'b110000);
        check_pixel("bg_cell", 100, 100, 1'b1);
        check_eq("bg_value", rgb, bg_color);
        check_pixel("blank", 70, 100, 1'b0);
        check_eq("blank_zero", rgb, 0);
        check_pixel("off_grid", GW * CELL + 5, 10, 1'b1);

        repeat (240) begin
            run_frame($urandom_range(6, 1), $urandom_range(4, 0) == 0);
            check_pixels();
        end

        // Long vsync: exactly one tick
        run_frame(500, 1'b0);
        check_pixels();

        // Reset landing between frame_tick and the step it would cause
        while (mcnt != FPS - 1) run_frame(2, 1'b0);
        vsync = 1'b1;
        cyc();
        check_eq("mid_tick", frame_tick, 1);
        rst_n = 1'b0;
        vsync = 1'b0;
        dir_init = 2*NO'($urandom);
        fg_color = 6'($urandom);
        cyc();
        cyc();
        check_eq("mid_bounce", bounce_pulse, 0);
        check_eq("mid_corner", corner_hit, 0);
        check_eq("mid_rgb", rgb, 0);
        rst_n = 1'b1;
        model_reset();
        cyc();
        cyc();
        check_pixels();

        // vsync already high when reset releases: no tick until it falls
        rst_n = 1'b0;
        vsync = 1'b1;
        dir_init = 2*NO'($urandom);
        fg_color = 6'($urandom);
        cyc();
        cyc();
        rst_n = 1'b1;
        model_reset();
        repeat (20) begin
            cyc();
            check_eq("no_tick_high", frame_tick, 0);
        end
        vsync = 1'b0;
        cyc();
        cyc();
        cyc();
        check_pixels();

        repeat (240) begin
            run_frame($urandom_range(6, 1), $urandom_range(4, 0) == 0);
            check_pixels();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
